// File: rtl/operand_bus_arbiter.sv
// Round-robin arbiter for the shared operand bus: drives the 4-input operand
// mux select and captures the mux output into a registered valid/ready stage.
module operand_bus_arbiter #(
  parameter int S        = 32,
  parameter int V        = 192,
  parameter int MAX_LOCK = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [3:0]   req,
  input  logic [3:0]   lock,
  input  logic [V-1:0] bus_e,
  output logic [1:0]   sel,
  output logic [3:0]   gnt,
  output logic [V-1:0] out_data,
  output logic         out_valid,
  output logic [1:0]   out_src,
  input  logic         out_ready
);

  localparam int BW = $clog2(MAX_LOCK + 1);

  // Scalar sources are zero-extended by the mux, so they can never be wider.
  if (S > V) begin : g_scalar_wider_than_bus
  end

  typedef enum logic {IDLE, OWNED} mode_e;

  mode_e          mode_q, mode_d;
  logic [1:0]     ptr_q, ptr_d;
  logic [1:0]     owner_q, owner_d;
  logic [BW-1:0]  beat_cnt_q, beat_cnt_d;
  logic [1:0]     sel_q;
  logic [V-1:0]   out_data_q;
  logic           out_valid_q;
  logic [1:0]     out_src_q;

  logic           accept, take, locked;
  logic [1:0]     rr_w, win;

  // Scan downward so the entry nearest ptr overrides the others.
  always_comb begin
    rr_w = ptr_q;
    for (int k = 3; k >= 0; k--) begin
      if (req[ptr_q + 2'(k)]) rr_w = ptr_q + 2'(k);
    end
  end

  always_comb begin
    accept     = ~out_valid_q | out_ready;
    take       = rst_n & accept & (|req);
    locked     = (mode_q == OWNED) & req[owner_q] & (beat_cnt_q < BW'(MAX_LOCK));
    win        = locked ? owner_q : rr_w;
    gnt        = take ? (4'b0001 << win) : 4'b0000;
    sel        = take ? win : sel_q;

    ptr_d      = locked ? ptr_q : win + 2'd1;
    mode_d     = IDLE;
    owner_d    = owner_q;
    beat_cnt_d = '0;
    if (lock[win]) begin
      mode_d     = OWNED;
      owner_d    = win;
      beat_cnt_d = locked ? beat_cnt_q + BW'(1) : BW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q      <= IDLE;
      ptr_q       <= '0;
      owner_q     <= '0;
      beat_cnt_q  <= '0;
      sel_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_src_q   <= '0;
    end else if (take) begin
      mode_q      <= mode_d;
      ptr_q       <= ptr_d;
      owner_q     <= owner_d;
      beat_cnt_q  <= beat_cnt_d;
      sel_q       <= win;
      out_data_q  <= bus_e;
      out_valid_q <= 1'b1;
      out_src_q   <= win;
    end else if (out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_src   = out_src_q;

endmodule

// File: tb/tb_operand_bus_arbiter.sv
// Bench for operand_bus_arbiter: cycle-level reference model plus directed
// scenarios with hand-computed grant sequences.
module tb_operand_bus_arbiter;
  localparam int V  = 192;
  localparam int ML = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [3:0]   req = '0;
  logic [3:0]   lock = '0;
  logic [V-1:0] bus_e = '0;
  logic         out_ready = 1'b0;
  logic [1:0]   sel;
  logic [3:0]   gnt;
  logic [V-1:0] out_data;
  logic         out_valid;
  logic [1:0]   out_src;

  operand_bus_arbiter #(.S(32), .V(V), .MAX_LOCK(ML)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .lock(lock), .bus_e(bus_e),
    .sel(sel), .gnt(gnt), .out_data(out_data), .out_valid(out_valid),
    .out_src(out_src), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  int vec_cnt = 0;
  int err_cnt = 0;

  task automatic chk(input string nm, input logic [V-1:0] got, input logic [V-1:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  // Reference model: who is in the current tenure and how many beats it took.
  int           m_ptr = 0, m_owner = 0, m_beats = 0, m_sel = 0, m_src = 0;
  bit           m_owned = 0, m_ov = 0;
  logic [V-1:0] m_data = '0;
  bit           s_g = 0, s_locked = 0, s_lk = 0, s_ready = 0;
  int           s_w = 0;
  logic [V-1:0] s_data = '0;

  always @(negedge clk) begin
    bit g, lk_beat;
    int w;
    logic [3:0] eg;
    int es;
    g       = rst_n && (!m_ov || out_ready) && (req != 4'b0000);
    lk_beat = m_owned && req[m_owner] && (m_beats < ML);
    w       = 0;
    if (lk_beat) w = m_owner;
    else for (int k = 3; k >= 0; k--) if (req[(m_ptr + k) % 4]) w = (m_ptr + k) % 4;
    eg = g ? (4'b0001 << w) : 4'b0000;
    es = g ? w : m_sel;
    chk("model_gnt", V'(gnt), V'(eg));
    chk("model_sel", V'(sel), V'(es));
    chk("model_out_valid", V'(out_valid), V'(m_ov));
    chk("model_out_src", V'(out_src), V'(m_src));
    chk("model_out_data", out_data, m_data);
    s_g      <= g;
    s_w      <= w;
    s_locked <= lk_beat;
    s_lk     <= lock[w];
    s_data   <= bus_e;
    s_ready  <= out_ready;
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ptr <= 0; m_owner <= 0; m_beats <= 0; m_sel <= 0; m_src <= 0;
      m_owned <= 0; m_ov <= 0; m_data <= '0; s_g <= 0;
    end else begin
      if (s_g) begin
        m_data <= s_data; m_src <= s_w; m_ov <= 1; m_sel <= s_w;
        if (!s_locked) m_ptr <= (s_w + 1) % 4;
        if (s_lk) begin
          m_owned <= 1; m_owner <= s_w;
          m_beats <= s_locked ? m_beats + 1 : 1;
        end else begin
          m_owned <= 0; m_beats <= 0;
        end
      end else if (s_ready) begin
        m_ov <= 0;
      end
      s_g <= 0;
    end
  end

  logic [3:0] g_obs;

  task automatic cyc(input logic [3:0] r, input logic [3:0] l, input logic rdy,
                     input logic [V-1:0] d);
    @(posedge clk); #1;
    req = r; lock = l; out_ready = rdy; bus_e = d;
    @(negedge clk);
    g_obs = gnt;
  endtask

  logic [V-1:0] rot_d [5];
  int rot_w  [5]  = '{0, 1, 2, 3, 0};
  int lk_w   [10] = '{1, 1, 1, 1, 2, 1, 1, 1, 1, 2};
  int drop_w [5]  = '{2, 2, 3, 0, 1};
  logic [3:0] drop_r [5] = '{4'b0100, 4'b0100, 4'b1001, 4'b1001, 4'b0110};
  logic [3:0] drop_l [5] = '{4'b0100, 4'b0100, 4'b0000, 4'b0000, 4'b0000};

  initial begin
    rot_d[0] = {24{8'hA5}};
    rot_d[1] = V'(1);
    rot_d[2] = V'(2);
    rot_d[3] = V'(3);
    rot_d[4] = V'(4);

    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Start a locked tenure on source 0, then reset in the middle of it.
    cyc(4'b0001, 4'b0001, 1'b1, V'(55));
    chk("lock0_beat1", V'(g_obs), V'(4'b0001));
    cyc(4'b0001, 4'b0001, 1'b1, V'(56));
    chk("lock0_beat2", V'(g_obs), V'(4'b0001));
    #2 rst_n = 1'b0;
    #1;
    chk("rst_out_valid", V'(out_valid), V'(0));
    chk("rst_gnt", V'(gnt), V'(0));
    chk("rst_sel", V'(sel), V'(0));
    chk("rst_out_data", out_data, V'(0));
    @(posedge clk); #1;
    rst_n = 1'b1; req = 4'b1000; lock = 4'b0000; out_ready = 1'b1; bus_e = V'(77);
    @(negedge clk);
    chk("post_rst_gnt", V'(gnt), V'(4'b1000));

    for (int i = 0; i < 5; i++) begin
      cyc(4'b1111, 4'b0000, 1'b1, rot_d[i]);
      chk("rot_gnt", V'(g_obs), V'(4'b0001 << rot_w[i]));
      if (i > 0) begin
        chk("rot_out_data", out_data, rot_d[i-1]);
        chk("rot_out_src", V'(out_src), V'(rot_w[i-1]));
      end
    end

    for (int i = 0; i < 10; i++) begin
      cyc(4'b0110, 4'b0010, 1'b1, V'(200 + i));
      chk("lock_limit_gnt", V'(g_obs), V'(4'b0001 << lk_w[i]));
    end

    for (int i = 0; i < 9; i++) begin
      cyc(4'b0010, 4'b0010, 1'b1, V'(100 + i));
      chk("solo_gnt", V'(g_obs), V'(4'b0010));
    end

    for (int i = 0; i < 3; i++) begin
      cyc(4'b0101, 4'b0000, 1'b0, V'(300 + i));
      chk("bp_gnt", V'(g_obs), V'(0));
      chk("bp_out_data", out_data, V'(108));
      chk("bp_out_valid", V'(out_valid), V'(1));
    end
    cyc(4'b0101, 4'b0000, 1'b1, V'(400));
    chk("bp_release_gnt", V'(g_obs), V'(4'b0100));

    for (int i = 0; i < 5; i++) begin
      cyc(drop_r[i], drop_l[i], 1'b1, V'(500 + i));
      chk("owner_drop_gnt", V'(g_obs), V'(4'b0001 << drop_w[i]));
      if (i == 0) chk("bp_refill_valid", V'(out_valid), V'(1));
    end

    cyc(4'b0001, 4'b0000, 1'b1, V'(777));
    chk("drain_beat_gnt", V'(g_obs), V'(4'b0001));
    cyc(4'b0000, 4'b0000, 1'b1, V'(0));
    chk("drain_gnt", V'(g_obs), V'(0));
    chk("drain_sel", V'(sel), V'(0));
    chk("drain_valid_held", V'(out_valid), V'(1));
    cyc(4'b0000, 4'b0000, 1'b1, V'(0));
    chk("drain_valid_fell", V'(out_valid), V'(0));
    chk("drain_sel_hold", V'(sel), V'(0));
    chk("drain_data_hold", out_data, V'(777));

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule

// File: doc/operand_bus_arbiter.md
# operand_bus_arbiter

Round-robin arbiter and sequencer for the shared 192-bit operand bus in the vector datapath. It drives the select lines of the 4-input operand mux and captures the mux output into a registered valid/ready stage for the execute unit. The four mux sources are the vector register read port and scalar sources A, B and C. It supports locked multi-beat tenures with a bounded lock length, so no source is starved.

## Interface
- S, 32: scalar operand width (mux sources A/B/C; zero-extended by the mux)
- V, 192: vector operand and bus width
- MAX_LOCK, 4: maximum consecutive locked beats per tenure (≥1)
- clk  in  1  sole clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req  in  4  per-source request; bit i ↔ mux sel code i (0=vector D, 1=A, 2=B, 3=C)
- lock  in  4  per-source lock request, sampled only with req[i]
- bus_e  in  V  operand mux output (E)
- sel  out  2  operand mux select
- gnt  out  4  one-hot grant, combinational, asserted in the cycle the beat is taken
- out_data  out  V  registered operand
- out_valid  out  1  out_data holds an untaken beat
- out_src  out  2  source code of out_data
- out_ready  in  1  consumer accepts out_data

## Operation
- accept = ~out_valid | out_ready. There are no grants when accept=0.
- Registered state:
  - ptr[1:0]: round-robin start.
  - mode: IDLE or OWNED.
  - owner[1:0].
  - beat_cnt: counts 0..MAX_LOCK.
  - sel_q[1:0].
- Winner selection when accept=1 and req≠0:
  - OWNED, req[owner]=1 and beat_cnt<MAX_LOCK: winner=owner (locked beat).
  - Otherwise: round-robin winner, the first i in ptr, ptr+1, ptr+2, ptr+3 (mod 4) with req[i]=1.
- On a grant to w:
  - gnt[w]=1 and sel=w. At the edge: out_data←bus_e, out_src←w, out_valid←1, sel_q←w.
  - Round-robin grant: ptr←w+1 (mod 4). If lock[w]: mode←OWNED, owner←w, beat_cnt←1. Else mode←IDLE, beat_cnt←0.
  - Locked grant: ptr unchanged. If lock[w]: beat_cnt←beat_cnt+1. Else mode←IDLE, beat_cnt←0 (this is the last beat).
- Tenure release:
  - If req[owner] drops while OWNED, the tenure ends. Arbitration that cycle is round-robin, and mode goes IDLE unless the new winner locks.
  - When beat_cnt=MAX_LOCK, arbitration is forced to round-robin. Since ptr=owner+1, other pending sources win first. If only the owner requests, it wins a fresh tenure with beat_cnt=1.
- No grant in a cycle: sel=sel_q, gnt=0, and ptr/mode/owner/beat_cnt hold.
- Drain without refill: out_valid=1, out_ready=1 and no winner gives out_valid←0 at the edge. out_data and out_src hold their last values.
- Simultaneous drain and refill is legal: one beat per cycle at full throughput.

## Timing
- Reset (async assert, sync release):
  - Outputs: out_valid=0, out_data=0, out_src=0, gnt=0, sel=0.
  - Internal state: ptr=0, mode=IDLE, beat_cnt=0, sel_q=0.
  - A reset mid-tenure or mid-backpressure discards the pending beat.
- Latency: req asserted in cycle t with accept=1 gives gnt/sel in t (combinational) and out_valid/out_data in t+1.
- Backpressure: while out_valid=1 and out_ready=0:
  - out_data and out_src are stable.
  - gnt=0, sel=sel_q.
  - No arbitration state changes.
- gnt is a function of req, lock, out_valid, out_ready and registered state only, never of bus_e.
- bus_e must be stable by the edge ending a granted cycle. The mux is combinational on sel.
- Locked tenure worst-case wait for another requester: MAX_LOCK+3 grants.

## Test plan
- Reset: assert rst_n=0 mid-tenure with out_valid=1 -> out_valid=0, gnt=0, sel=0 immediately. After release with req=4'b1000, first gnt=4'b1000 (ptr starts at 0, so scan 0,1,2,3).
- Fair rotation: req=4'b1111, lock=0, out_ready=1 -> gnt order 0,1,2,3,0. out_src lags gnt by 1 cycle, and out_data equals the bus_e value driven in each grant cycle (e.g. 192'hA5…, 192'h1, 192'h2, 192'h3).
- Lock limit (MAX_LOCK=4): req=4'b0110, lock=4'b0010 -> grants 1,1,1,1,2,1,1,1,1,2. With req=4'b0010 only -> continuous grants to 1, and beat_cnt restarts at 1 after every 4 beats.
- Backpressure: out_valid=1, out_ready=0 for 3 cycles with req=4'b0101 -> gnt=0, out_data constant, ptr unchanged. Raising out_ready -> same-cycle drain plus new grant, out_valid stays 1.
- Owner drop: OWNED by 2 at beat_cnt=2, req[2] falls while req=4'b1001 -> round-robin grant from ptr=3 to source 3, and mode=IDLE after the beat.
- Idle drain: a single beat from source 0, then req=0 with out_ready=1 -> out_valid falls next cycle, and sel holds at 0.
